// File: rtl/forward_pass_engine.sv
// Sequential 10-5-3 forward pass: one MAC per cycle, hard-sigmoid activations registered per neuron.
// Latency: done pulses N_IN*N_HID + N_HID*N_OUT + 3 cycles after start; no backpressure, weight data returns one cycle after each read.
module forward_pass_engine #(
  parameter int N_IN  = 10,
  parameter int N_HID = 5,
  parameter int N_OUT = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [N_IN-1:0][9:0]    i_x,
  output logic                    o_w_rd,
  output logic [6:0]              o_w_addr,
  input  logic signed [9:0]       i_w_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N_HID-1:0][9:0]   o_out0_cal,
  output logic [N_OUT-1:0][9:0]   o_out1_cal
);

  localparam logic [6:0] LAST_H_ADDR = 7'(N_IN*N_HID - 1);
  localparam logic [6:0] LAST_ADDR   = 7'(N_IN*N_HID + N_HID*N_OUT - 1);
  localparam logic [3:0] LAST_I_HID  = 4'(N_IN - 1);
  localparam logic [3:0] LAST_I_OUT  = 4'(N_HID - 1);
  localparam logic [2:0] LAST_N_HID  = 3'(N_HID - 1);

  typedef enum logic [2:0] {S_IDLE, S_HIDDEN, S_GAP, S_OUTPUT, S_DRAIN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    w_rd_nxt, w_accept;
  logic                    r_w_rd, r_rd_d;
  logic [6:0]              r_w_addr;
  logic [N_IN-1:0][9:0]    r_x;
  logic [N_HID-1:0][9:0]   r_out0;
  logic [N_OUT-1:0][9:0]   r_out1;
  logic signed [24:0]      r_acc;
  logic [3:0]              r_mi;
  logic [2:0]              r_mn;
  logic                    r_ml;

  logic [9:0]              w_op;
  logic signed [20:0]      w_prod;
  logic signed [24:0]      w_sum, w_shift, w_y_full;
  logic [9:0]              w_y;
  logic                    w_first, w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) begin w_state_nxt = S_HIDDEN; w_rd_nxt = 1'b1; end
      S_HIDDEN: begin
        w_rd_nxt = 1'b1;
        if (r_w_addr == LAST_H_ADDR) begin w_state_nxt = S_GAP; w_rd_nxt = 1'b0; end
      end
      S_GAP:    begin w_state_nxt = S_OUTPUT; w_rd_nxt = 1'b1; end
      S_OUTPUT: begin
        w_rd_nxt = 1'b1;
        if (r_w_addr == LAST_ADDR) begin w_state_nxt = S_DRAIN; w_rd_nxt = 1'b0; end
      end
      S_DRAIN:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && i_start;

  // Term counters track the data returning this cycle, one cycle behind the read side.
  assign w_op     = r_ml ? r_out0[r_mi[2:0]] : r_x[r_mi];
  assign w_prod   = $signed({1'b0, w_op}) * i_w_data;
  assign w_first  = (r_mi == 4'd0);
  assign w_last   = r_ml ? (r_mi == LAST_I_OUT) : (r_mi == LAST_I_HID);
  assign w_sum    = (w_first ? 25'sd0 : r_acc) + $signed({{4{w_prod[20]}}, w_prod});
  assign w_shift  = w_sum >>> 9;
  assign w_y_full = w_shift + 25'sd512;
  assign w_y      = (w_y_full < 25'sd0) ? 10'd0 :
                    (w_y_full > 25'sd1023) ? 10'd1023 : w_y_full[9:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_w_rd   <= 1'b0;
      r_w_addr <= '0;
      r_rd_d   <= 1'b0;
      r_x      <= '0;
      r_out0   <= '0;
      r_out1   <= '0;
      r_acc    <= '0;
      r_mi     <= '0;
      r_mn     <= '0;
      r_ml     <= 1'b0;
    end else begin
      r_w_rd <= w_rd_nxt;
      r_rd_d <= r_w_rd;
      if (w_accept) begin
        r_w_addr <= '0;
        r_x      <= i_x;
        r_mi     <= '0;
        r_mn     <= '0;
        r_ml     <= 1'b0;
      end else begin
        if (w_rd_nxt) r_w_addr <= r_w_addr + 7'd1;
        if (r_rd_d) begin
          r_acc <= w_sum;
          if (w_last) begin
            if (!r_ml) r_out0[r_mn]      <= w_y;
            else       r_out1[r_mn[1:0]] <= w_y;
            r_mi <= '0;
            if (!r_ml && r_mn == LAST_N_HID) begin
              r_mn <= '0;
              r_ml <= 1'b1;
            end else begin
              r_mn <= r_mn + 3'd1;
            end
          end else begin
            r_mi <= r_mi + 4'd1;
          end
        end
      end
    end
  end

  assign o_w_rd     = r_w_rd;
  assign o_w_addr   = r_w_addr;
  assign o_busy     = (r_state == S_HIDDEN) || (r_state == S_GAP) ||
                      (r_state == S_OUTPUT) || (r_state == S_DRAIN);
  assign o_done     = (r_state == S_DONE);
  assign o_out0_cal = r_out0;
  assign o_out1_cal = r_out1;

endmodule

// File: tb/tb_forward_pass_engine.sv
// Bench for forward_pass_engine: table vectors, randomized passes against an arithmetic model,
// and hand-written control sequences (ignored starts, mid-pass reset).
module tb_forward_pass_engine;
  localparam int N_IN  = 10;
  localparam int N_HID = 5;
  localparam int N_OUT = 3;
  localparam int N_W   = N_IN*N_HID + N_HID*N_OUT;

  logic                  clk = 1'b0;
  logic                  rst_n, start;
  logic [N_IN-1:0][9:0]  x;
  logic                  w_rd;
  logic [6:0]            w_addr;
  logic signed [9:0]     w_data;
  logic                  busy, done;
  logic [N_HID-1:0][9:0] out0;
  logic [N_OUT-1:0][9:0] out1;

  always #5 clk = ~clk;

  forward_pass_engine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_x(x),
    .o_w_rd(w_rd), .o_w_addr(w_addr), .i_w_data(w_data),
    .o_busy(busy), .o_done(done), .o_out0_cal(out0), .o_out1_cal(out1)
  );

  int wmem[N_W];
  int xv[N_IN];
  int exp0[N_HID];
  int exp1[N_OUT];
  int checks = 0;
  int failures = 0;

  // Weight memory: data is valid only the cycle after a read; junk otherwise.
  always @(posedge clk) begin
    if (w_rd === 1'b1) w_data <= 10'(wmem[int'(w_addr)]);
    else               w_data <= 10'($urandom);
  end

  typedef struct {
    int x[N_IN];
    int w[N_W];
    int e0[N_HID];
    int e1[N_OUT];
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int hsig(input longint s);
    longint q;
    q = s / 512;
    if ((s % 512 != 0) && (s < 0)) q = q - 1;
    q = q + 512;
    if (q < 0) q = 0;
    if (q > 1023) q = 1023;
    return int'(q);
  endfunction

  task automatic model();
    longint s;
    for (int j = 0; j < N_HID; j++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(xv[i]) * longint'(wmem[N_IN*j + i]);
      exp0[j] = hsig(s);
    end
    for (int k = 0; k < N_OUT; k++) begin
      s = 0;
      for (int j = 0; j < N_HID; j++) s += longint'(exp0[j]) * longint'(wmem[N_IN*N_HID + N_HID*k + j]);
      exp1[k] = hsig(s);
    end
  endtask

  task automatic apply_x();
    for (int i = 0; i < N_IN; i++) x[i] = 10'(xv[i]);
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < N_IN; i++) xv[i] = vt[v].x[i];
    for (int a = 0; a < N_W; a++) wmem[a] = vt[v].w[a];
    for (int j = 0; j < N_HID; j++) exp0[j] = vt[v].e0[j];
    for (int k = 0; k < N_OUT; k++) exp1[k] = vt[v].e1[k];
  endtask

  task automatic check_outputs(input string tag);
    for (int j = 0; j < N_HID; j++) chk($sformatf("%s out0_cal[%0d]", tag, j), int'(out0[j]), exp0[j]);
    for (int k = 0; k < N_OUT; k++) chk($sformatf("%s out1_cal[%0d]", tag, k), int'(out1[k]), exp1[k]);
  endtask

  // Starts a pass (cycle 0 = start sampled) and checks the cycle-by-cycle protocol up to done.
  task automatic run_pass(input string tag, input bit extra_starts);
    int exp_addr, ndone;
    bit exp_rd;
    @(negedge clk);
    apply_x();
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      exp_rd   = (c <= 50) || (c >= 52 && c <= 66);
      exp_addr = (c <= 50) ? c - 1 : (c == 51) ? 49 : (c <= 66) ? c - 2 : 64;
      chk($sformatf("%s w_rd c%0d", tag, c), int'(w_rd), int'(exp_rd));
      chk($sformatf("%s w_addr c%0d", tag, c), int'(w_addr), exp_addr);
      chk($sformatf("%s busy c%0d", tag, c), int'(busy), (c <= 67) ? 1 : 0);
      chk($sformatf("%s done c%0d", tag, c), int'(done), (c == 68) ? 1 : 0);
      for (int j = 0; j < N_HID; j++)
        if (c == 10*j + 12) chk($sformatf("%s out0_cal[%0d] c%0d", tag, j, c), int'(out0[j]), exp0[j]);
      for (int k = 0; k < N_OUT; k++)
        if (c == 5*k + 58) chk($sformatf("%s out1_cal[%0d] c%0d", tag, k, c), int'(out1[k]), exp1[k]);
      start = extra_starts && (c == 10 || c == 68);
      x = {N_IN{10'($urandom)}};
    end
    @(negedge clk);
    start = 1'b0;
    check_outputs({tag, " final"});
    if (extra_starts) begin
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (done === 1'b1) ndone++;
      end
      chk({tag, " extra done pulses"}, ndone, 0);
      check_outputs({tag, " held"});
    end
  endtask

  initial begin
    // Table: x, weights, expected hidden and output activations.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N_IN; i++) vt[v].x[i] = 0;
      for (int a = 0; a < N_W; a++) vt[v].w[a] = 0;
      for (int j = 0; j < N_HID; j++) vt[v].e0[j] = 512;
      for (int k = 0; k < N_OUT; k++) vt[v].e1[k] = 512;
    end
    for (int i = 0; i < N_IN; i++) vt[0].x[i] = int'($urandom_range(0, 1023));
    vt[1].x[0] = 1023; vt[1].w[0] = 128;  vt[1].w[50] = 128;
    vt[1].e0[0] = 767; vt[1].e1[0] = 703;
    vt[2].x[0] = 1023; vt[2].w[0] = -128; vt[2].w[50] = 128;
    vt[2].e0[0] = 256; vt[2].e1[0] = 576;
    for (int i = 0; i < N_IN; i++) begin vt[3].x[i] = 1023; vt[4].x[i] = 1023; end
    for (int a = 0; a < N_W; a++) begin vt[3].w[a] = 511; vt[4].w[a] = -512; end
    for (int j = 0; j < N_HID; j++) begin vt[3].e0[j] = 1023; vt[4].e0[j] = 0; end
    // Hidden layer floors at 0, so every output-layer sum is 0: sigmoid midpoint.
    for (int k = 0; k < N_OUT; k++) begin vt[3].e1[k] = 1023; vt[4].e1[k] = 512; end

    rst_n = 1'b0;
    start = 1'b1;
    x = {N_IN{10'($urandom)}};
    for (int a = 0; a < N_W; a++) wmem[a] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset w_rd", int'(w_rd), 0);
    chk("reset w_addr", int'(w_addr), 0);
    chk("reset out0 bus", int'(out0 != '0), 0);
    chk("reset out1 bus", int'(out1 != '0), 0);
    rst_n = 1'b1;
    start = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_pass($sformatf("vec%0d", v), 1'b0);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 1023));
      for (int a = 0; a < N_W; a++)
        wmem[a] = (r % 2 == 0) ? int'($urandom_range(0, 47)) - 24 : int'($urandom_range(0, 1023)) - 512;
      model();
      run_pass($sformatf("rand%0d", r), 1'b0);
    end

    load_vec(1);
    run_pass("ignored starts", 1'b1);

    // Mid-pass reset: no done afterwards and all results cleared.
    load_vec(3);
    @(negedge clk);
    apply_x();
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 30) rst_n = 1'b0;
      if (c == 31) rst_n = 1'b1;
    end
    begin
      int ndone;
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (done === 1'b1) ndone++;
      end
      chk("abort done pulses", ndone, 0);
    end
    chk("abort busy", int'(busy), 0);
    chk("abort w_addr", int'(w_addr), 0);
    for (int j = 0; j < N_HID; j++) exp0[j] = 0;
    for (int k = 0; k < N_OUT; k++) exp1[k] = 0;
    check_outputs("abort");

    load_vec(2);
    run_pass("after abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
